// File: rtl/cmult_pkg.sv
// cmult_pkg: widths, rounding constant and limit helpers shared by the
// complex multiplier pipeline and its round/saturate stage.
package cmult_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int FRAC_BITS_DEF  = 15;
   localparam int TAG_WIDTH_DEF  = 8;

   // One product of a W-bit and a (W+1)-bit signed operand.
   function automatic int prod_w(int dw);
      return 2 * dw + 1;
   endfunction

   // Sum/difference of two products, one guard bit above the product width.
   function automatic int sum_w(int dw);
      return 2 * dw + 2;
   endfunction

   // Half an output LSB, added before the arithmetic shift (round half up).
   function automatic longint rnd_const(int fb);
      return (fb > 0) ? (longint'(1) << (fb - 1)) : longint'(0);
   endfunction

   function automatic longint smax(int dw);
      return (longint'(1) << (dw - 1)) - 1;
   endfunction

   function automatic longint smin(int dw);
      return -(longint'(1) << (dw - 1));
   endfunction

endpackage

// File: rtl/cmult_pipe_if.sv
// cmult_pipe_if: valid/ready input and output channels of the complex
// multiplier. master = producer/consumer side, slave = the multiplier.
interface cmult_pipe_if #(
   parameter int DATA_WIDTH = 16,
   parameter int TAG_WIDTH  = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_conj;
   logic [DATA_WIDTH-1:0] a_real;
   logic [DATA_WIDTH-1:0] a_imag;
   logic [DATA_WIDTH-1:0] b_real;
   logic [DATA_WIDTH-1:0] b_imag;
   logic [TAG_WIDTH-1:0]  in_tag;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_real;
   logic [DATA_WIDTH-1:0] out_imag;
   logic [TAG_WIDTH-1:0]  out_tag;
   logic                  out_ovf;

   modport master (
      output in_valid, in_conj, a_real, a_imag, b_real, b_imag, in_tag, out_ready,
      input  in_ready, out_valid, out_real, out_imag, out_tag, out_ovf
   );

   modport slave (
      input  in_valid, in_conj, a_real, a_imag, b_real, b_imag, in_tag, out_ready,
      output in_ready, out_valid, out_real, out_imag, out_tag, out_ovf
   );
endinterface

// File: rtl/cmult_round_sat.sv
// cmult_round_sat: round-half-up, arithmetic shift by FRAC_BITS and narrow
// one result component to DATA_WIDTH. With CMULT_SAT_EN defined the result
// clamps to the signed range and flags ovf_o; otherwise it wraps, ovf_o = 0.
module cmult_round_sat
   import cmult_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
   input  logic signed [sum_w(DATA_WIDTH)-1:0] sum_i,
   output logic        [DATA_WIDTH-1:0]        res_o,
   output logic                                ovf_o
);
   localparam int SW = sum_w(DATA_WIDTH);
   localparam logic signed [SW-1:0] RND = SW'(rnd_const(FRAC_BITS));

   logic signed [SW-1:0] rounded;
   logic signed [SW-1:0] shifted;

   // sum_i stays well inside SW bits, so adding half an LSB cannot overflow
   assign rounded = sum_i + RND;
   assign shifted = rounded >>> FRAC_BITS;

`ifdef CMULT_SAT_EN
   localparam logic signed [SW-1:0] MAXV = SW'(smax(DATA_WIDTH));
   localparam logic signed [SW-1:0] MINV = SW'(smin(DATA_WIDTH));

   // clamp anything outside the DATA_WIDTH signed range
   always_comb begin
      res_o = shifted[DATA_WIDTH-1:0];
      ovf_o = 1'b0;
      if (shifted > MAXV) begin
         res_o = MAXV[DATA_WIDTH-1:0];
         ovf_o = 1'b1;
      end else if (shifted < MINV) begin
         res_o = MINV[DATA_WIDTH-1:0];
         ovf_o = 1'b1;
      end
   end
`else
   logic unused_hi;

   // wrap: keep the low bits, the rest is intentionally discarded
   assign res_o     = shifted[DATA_WIDTH-1:0];
   assign ovf_o     = 1'b0;
   assign unused_hi = ^shifted[SW-1:DATA_WIDTH];
`endif

endmodule

// File: rtl/cmult_pipe.sv
// cmult_pipe: 3-stage pipelined signed complex multiplier, out = a*b or
// a*conj(b), fixed point with round half up. Global stall backpressure:
// every stage moves together when the output is free or being taken.
// Optional saturation: define CMULT_SAT_EN (default build wraps).
module cmult_pipe
   import cmult_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int FRAC_BITS  = FRAC_BITS_DEF,
   parameter int TAG_WIDTH  = TAG_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   cmult_pipe_if.slave  bus
);
   localparam int W  = DATA_WIDTH;
   localparam int PW = prod_w(DATA_WIDTH);
   localparam int SW = sum_w(DATA_WIDTH);

   logic adv;
   logic [3:1] vld_q;

   // S1: operands, b_imag one bit wider so -(-2^(W-1)) is exact
   logic signed [W-1:0]  s1_ar_q, s1_ai_q, s1_br_q;
   logic signed [W:0]    s1_bi_q, s1_bi_d;
   logic [TAG_WIDTH-1:0] s1_tag_q;

   // S2: the four partial products
   logic signed [PW-1:0] s2_prr_q, s2_pii_q, s2_pri_q, s2_pir_q;
   logic [TAG_WIDTH-1:0] s2_tag_q;

   // S3: rounded/narrowed result, which is also the output register
   logic signed [SW-1:0] re_d, im_d;
   logic [W-1:0]         re_n, im_n;
   logic                 ovf_re, ovf_im;
   logic [W-1:0]         s3_re_q, s3_im_q;
   logic [TAG_WIDTH-1:0] s3_tag_q;
   logic                 s3_ovf_q;

   // whole pipe advances unless a valid result is sitting unaccepted
   assign adv = !vld_q[3] || bus.out_ready;

   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_q[3];
   assign bus.out_real  = s3_re_q;
   assign bus.out_imag  = s3_im_q;
   assign bus.out_tag   = s3_tag_q;
   assign bus.out_ovf   = s3_ovf_q;

   // sign-extend b_imag, then negate for conjugate multiply
   always_comb begin
      s1_bi_d = {bus.b_imag[W-1], bus.b_imag};
      if (bus.in_conj) s1_bi_d = -s1_bi_d;
   end

   // valid shift register; bubbles move with the data, never collapse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vld_q <= '0;
      else if (adv) vld_q <= {vld_q[2:1], bus.in_valid};
   end

   // S1/S2 datapath; contents only matter where the matching valid is set
   always_ff @(posedge clk) begin
      if (adv) begin
         s1_ar_q  <= bus.a_real;
         s1_ai_q  <= bus.a_imag;
         s1_br_q  <= bus.b_real;
         s1_bi_q  <= s1_bi_d;
         s1_tag_q <= bus.in_tag;
         s2_prr_q <= PW'(s1_ar_q) * PW'(s1_br_q);
         s2_pii_q <= PW'(s1_ai_q) * PW'(s1_bi_q);
         s2_pri_q <= PW'(s1_ar_q) * PW'(s1_bi_q);
         s2_pir_q <= PW'(s1_ai_q) * PW'(s1_br_q);
         s2_tag_q <= s1_tag_q;
      end
   end

   assign re_d = SW'(s2_prr_q) - SW'(s2_pii_q);
   assign im_d = SW'(s2_pri_q) + SW'(s2_pir_q);

   cmult_round_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_rs_re (
      .sum_i (re_d),
      .res_o (re_n),
      .ovf_o (ovf_re)
   );

   cmult_round_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
   ) u_rs_im (
      .sum_i (im_d),
      .res_o (im_n),
      .ovf_o (ovf_im)
   );

   // output register, cleared by reset so idle outputs read as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_re_q  <= '0;
         s3_im_q  <= '0;
         s3_tag_q <= '0;
         s3_ovf_q <= 1'b0;
      end else if (adv) begin
         s3_re_q  <= re_n;
         s3_im_q  <= im_n;
         s3_tag_q <= s2_tag_q;
         s3_ovf_q <= ovf_re | ovf_im;
      end
   end

endmodule

// File: tb/tb_cmult_pipe.sv
// tb_cmult_pipe: directed and randomized checks of cmult_pipe against an
// arithmetic reference model and an in-order expectation queue.
module tb_cmult_pipe;
   localparam int W = 16;
   localparam int F = 15;
   localparam int T = 8;

   typedef struct packed {
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic [T-1:0] tag;
      logic         ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cmult_pipe_if #(.DATA_WIDTH(W), .TAG_WIDTH(T)) bus ();

   cmult_pipe #(.DATA_WIDTH(W), .FRAC_BITS(F), .TAG_WIDTH(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t q[$];
   int n_cmp = 0;
   int n_err = 0;
   int n_rx  = 0;
   logic acc, ov_seen, stall_prev;
   logic [2*W+T+1:0] snap;
   logic [W-1:0] last_re, last_im;
   logic last_ovf;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // floor((x + d/2) / d) with d = 2^F: round half up, then drop fraction
   function automatic longint rnd(longint x);
      longint d, n, r;
      d = longint'(1) << F;
      n = x + d / 2;
      r = n / d;
      if (n < 0 && (n % d) != 0) r = r - 1;
      return r;
   endfunction

   function automatic logic [W:0] fit(longint r);
      logic [W:0] o;
`ifdef CMULT_SAT_EN
      longint hi, lo;
      hi = 32767;
      lo = -32768;
      if (r > hi)      o = {1'b1, 16'h7FFF};
      else if (r < lo) o = {1'b1, 16'h8000};
      else             o = {1'b0, W'(r)};
`else
      o = {1'b0, W'(r)};
`endif
      return o;
   endfunction

   function automatic exp_t model(logic [W-1:0] ar, logic [W-1:0] ai, logic [W-1:0] br,
                                  logic [W-1:0] bi, logic conj, logic [T-1:0] tag);
      longint xr, xi, yr, yi;
      logic [W:0] fr, fi;
      exp_t e;
      xr = longint'($signed(ar));
      xi = longint'($signed(ai));
      yr = longint'($signed(br));
      yi = longint'($signed(bi));
      if (conj) yi = -yi;
      fr = fit(rnd(xr * yr - xi * yi));
      fi = fit(rnd(xr * yi + xi * yr));
      e.re  = fr[W-1:0];
      e.im  = fi[W-1:0];
      e.ovf = fr[W] | fi[W];
      e.tag = tag;
      return e;
   endfunction

   function automatic logic [W-1:0] rop();
      case ($urandom_range(7))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   // observe at negedge (checks + scoreboard), then step past the next posedge
   task automatic tick();
      exp_t e;
      @(negedge clk);
      acc = 1'b0;
      ov_seen = bus.out_valid;
      if (rst_n) begin
         chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
         if (stall_prev)
            chk("stall_hold", {bus.out_valid, bus.out_real, bus.out_imag, bus.out_tag, bus.out_ovf}, snap);
         if (q.size() == 0) chk("no_stale", bus.out_valid, 1'b0);
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("out_real", bus.out_real, e.re);
            chk("out_imag", bus.out_imag, e.im);
            chk("out_tag",  bus.out_tag,  e.tag);
            chk("out_ovf",  bus.out_ovf,  e.ovf);
            last_re  = bus.out_real;
            last_im  = bus.out_imag;
            last_ovf = bus.out_ovf;
            n_rx++;
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.a_real, bus.a_imag, bus.b_real, bus.b_imag, bus.in_conj, bus.in_tag));
            acc = 1'b1;
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         snap = {bus.out_valid, bus.out_real, bus.out_imag, bus.out_tag, bus.out_ovf};
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] ar, input logic [W-1:0] ai, input logic [W-1:0] br,
                        input logic [W-1:0] bi, input logic conj, input logic [T-1:0] tag);
      bus.a_real = ar; bus.a_imag = ai; bus.b_real = br; bus.b_imag = bi;
      bus.in_conj = conj; bus.in_tag = tag; bus.in_valid = 1'b1;
   endtask

   // one isolated sample: accepted at once, result seen exactly 3 cycles on
   task automatic send_one(input logic [W-1:0] ar, input logic [W-1:0] ai, input logic [W-1:0] br,
                           input logic [W-1:0] bi, input logic conj, input logic [T-1:0] tag);
      int lat;
      drive(ar, ai, br, bi, conj, tag);
      tick();
      chk("accepted", acc, 1'b1);
      bus.in_valid = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!ov_seen && lat < 10);
      chk("latency", lat, 3);
   endtask

   initial begin
      int nxt, cyc;
      logic presenting;
      bus.in_valid = 1'b0; bus.in_conj = 1'b0; bus.in_tag = '0;
      bus.a_real = '0; bus.a_imag = '0; bus.b_real = '0; bus.b_imag = '0;
      bus.out_ready = 1'b1;
      stall_prev = 1'b0; snap = '0;
      last_re = '0; last_im = '0; last_ovf = 1'b0;

      // reset state
      #12;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_real",  bus.out_real,  16'h0);
      chk("rst_out_imag",  bus.out_imag,  16'h0);
      chk("rst_out_tag",   bus.out_tag,   8'h0);
      chk("rst_out_ovf",   bus.out_ovf,   1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_in_ready", bus.in_ready, 1'b1);

      // directed arithmetic
      send_one(16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0, 8'h11);
      chk("t1_re", last_re, 16'h4000);
      chk("t1_im", last_im, 16'h0000);
      send_one(16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b1, 8'h22);
      chk("t2_re", last_re, 16'h0000);
      chk("t2_im", last_im, 16'h4000);
      // 0.5 * (1 - 2^-15) = 0x3FFF.8, half up gives 0x4000
      send_one(16'h4000, 16'h4000, 16'h7FFF, 16'h0000, 1'b0, 8'h33);
      chk("t2b_re", last_re, 16'h4000);
      chk("t2b_im", last_im, 16'h4000);
      send_one(16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 8'h44);
      chk("t3_half_up", last_re, 16'h0001);
      send_one(16'h0001, 16'h0000, 16'h3FFF, 16'h0000, 1'b0, 8'h55);
      chk("t3_below_half", last_re, 16'h0000);
      send_one(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 8'h66);
`ifdef CMULT_SAT_EN
      chk("t4_re", last_re, 16'h7FFF);
      chk("t4_ovf", last_ovf, 1'b1);
`else
      chk("t4_re", last_re, 16'h8000);
      chk("t4_ovf", last_ovf, 1'b0);
`endif

      // streaming with a 5-cycle stall, then random backpressure
      nxt = 0; cyc = 0; n_rx = 0; presenting = 1'b0;
      while ((nxt < 16 || q.size() > 0) && cyc < 400) begin
         if (!presenting && nxt < 16 && $urandom_range(3) != 0) begin
            drive(rop(), rop(), rop(), rop(), 1'($urandom_range(1)), T'(nxt));
            presenting = 1'b1;
         end
         if (cyc >= 6 && cyc < 11) bus.out_ready = 1'b0;
         else if (cyc >= 11)       bus.out_ready = 1'($urandom_range(1));
         else                      bus.out_ready = 1'b1;
         tick();
         if (acc) begin
            presenting = 1'b0;
            bus.in_valid = 1'b0;
            nxt++;
         end
         cyc++;
      end
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b0;
      chk("stream_sent", nxt, 16);
      chk("stream_rx", n_rx, 16);
      chk("stream_empty", q.size(), 0);

      // reset with three samples in flight
      for (int k = 0; k < 3; k++) begin
         drive(rop(), rop(), rop(), rop(), 1'b0, T'(8'hA0 + k));
         tick();
      end
      bus.in_valid = 1'b0;
      chk("pre_reset_valid", bus.out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_valid_drop", bus.out_valid, 1'b0);
      chk("async_tag_clear", bus.out_tag, 8'h0);
      q.delete();
      stall_prev = 1'b0;
      #20;
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("post_reset_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
